deser_frame_scheduler: RTL and testbench

Shares one serial deserializer between up to NUM_REQ requesters. Arbitrates round-robin, starts the deserializer for one frame on behalf of the winner, and buffers each completed word in a small FIFO. Streams the words to the granted requester over a valid/ready port, then reports frame status with a one-cycle done pulse. Sits between the serial-receive datapath and its consumer blocks.

---
 rtl/deser_pkg.sv | 28 ++
 rtl/deser_word_fifo.sv | 57 +++++
 rtl/deser_frame_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_deser_frame_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared types for the deserializer frame scheduler: FSM states, frame status codes
// and a width helper used to size counters and pointers.
package deser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        COLLECT,
        DRAIN,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        STATUS_OK  = 2'b00,
        STATUS_LEN = 2'b01,
        STATUS_OVF = 2'b10,
        STATUS_TMO = 2'b11
    } status_e;

    // Bits needed to index 'value' items; never less than 1 so vectors stay legal.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/deser_word_fifo.sv
// Small synchronous word FIFO. A push at full is accepted only when a pop frees a slot
// in the same cycle; the head word reads as zero while the FIFO is empty.
module deser_word_fifo
    import deser_pkg::*;
#(
    parameter int WORD_SIZE  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             push,
    input  logic [WORD_SIZE-1:0]             push_data,
    input  logic                             pop,
    output logic [WORD_SIZE-1:0]             pop_data,
    output logic                             full,
    output logic                             empty,
    output logic [clog2(FIFO_DEPTH+1)-1:0]   count
);
    localparam int PTR_W = clog2(FIFO_DEPTH);
    localparam int CNT_W = clog2(FIFO_DEPTH + 1);

    logic [WORD_SIZE-1:0] mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic                 push_ok;
    logic                 pop_ok;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_W'(FIFO_DEPTH));
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = empty ? '0 : mem_reg[rd_ptr_reg];
    assign count    = count_reg;

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_reg[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/deser_frame_scheduler.sv
// Round-robin scheduler sharing one deserializer: grants a requester, runs one frame,
// buffers its words for the owner and reports frame status with a done pulse.
module deser_frame_scheduler
    import deser_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int WORD_SIZE       = 8,
    parameter int WORDS_PER_FRAME = 2,
    parameter int FIFO_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 done,
    output logic [1:0]           status,
    output logic                 deser_start,
    output logic                 deser_abort,
    input  logic                 deser_busy,
    input  logic                 deser_rco,
    input  logic [WORD_SIZE-1:0] deser_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_data
);
    localparam int IDX_W  = clog2(NUM_REQ);
    localparam int WCNT_W = clog2(WORDS_PER_FRAME + 2);
    localparam int TCNT_W = clog2(TIMEOUT_CYCLES);
    localparam int CNT_W  = clog2(FIFO_DEPTH + 1);

    state_e             state_reg;
    status_e            status_reg;
    status_e            status_next;
    logic [NUM_REQ-1:0] grant_reg;
    logic [IDX_W-1:0]   grant_idx_reg;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [IDX_W-1:0]   rr_next;
    logic [WCNT_W-1:0]  word_cnt_reg;
    logic [TCNT_W-1:0]  tmo_cnt_reg;
    logic               tmo_flag_reg;
    logic               ovf_flag_reg;
    logic               done_reg;
    logic               start_reg;
    logic               abort_reg;

    logic [NUM_REQ-1:0] req_rot;
    logic [IDX_W-1:0]   pick_ofs;
    logic [IDX_W:0]     pick_sum;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               pick_valid;

    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    // Rotate requests so bit 0 is the requester at rr_ptr, then take the lowest set bit.
    assign req_rot = NUM_REQ'({req, req} >> rr_ptr_reg);

    always_comb begin
        pick_valid = 1'b0;
        pick_ofs   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_valid = 1'b1;
                pick_ofs   = IDX_W'(i);
            end
        end
    end

    assign pick_sum = {1'b0, rr_ptr_reg} + {1'b0, pick_ofs};
    assign pick_idx = (pick_sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(pick_sum - (IDX_W+1)'(NUM_REQ))
                                                        : IDX_W'(pick_sum);
    assign rr_next  = (grant_idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_reg + 1'b1;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
    end

    always_comb begin
        if (tmo_flag_reg)                                 status_next = STATUS_TMO;
        else if (ovf_flag_reg)                            status_next = STATUS_OVF;
        else if (word_cnt_reg != WCNT_W'(WORDS_PER_FRAME)) status_next = STATUS_LEN;
        else                                              status_next = STATUS_OK;
    end

    assign push = (state_reg == COLLECT) && deser_rco;
    assign pop  = out_valid && out_ready;

    deser_word_fifo #(
        .WORD_SIZE  (WORD_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (deser_data),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            status_reg    <= STATUS_OK;
            grant_reg     <= '0;
            grant_idx_reg <= '0;
            rr_ptr_reg    <= '0;
            word_cnt_reg  <= '0;
            tmo_cnt_reg   <= '0;
            tmo_flag_reg  <= 1'b0;
            ovf_flag_reg  <= 1'b0;
            done_reg      <= 1'b0;
            start_reg     <= 1'b0;
            abort_reg     <= 1'b0;
        end else begin
            start_reg <= 1'b0;
            abort_reg <= 1'b0;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        grant_idx_reg <= pick_idx;
                        grant_reg     <= pick_onehot;
                        start_reg     <= 1'b1;
                        state_reg     <= START;
                    end
                end
                START: begin
                    word_cnt_reg <= '0;
                    tmo_cnt_reg  <= '0;
                    tmo_flag_reg <= 1'b0;
                    ovf_flag_reg <= 1'b0;
                    state_reg    <= COLLECT;
                end
                COLLECT: begin
                    if (push && word_cnt_reg != WCNT_W'(WORDS_PER_FRAME + 1))
                        word_cnt_reg <= word_cnt_reg + 1'b1;
                    if (push && fifo_full && !pop)
                        ovf_flag_reg <= 1'b1;
                    // Timeout wins over a simultaneous busy drop.
                    if (tmo_cnt_reg == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                        abort_reg    <= 1'b1;
                        tmo_flag_reg <= 1'b1;
                        state_reg    <= DRAIN;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                        if (!deser_busy) state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_count == '0) begin
                        done_reg   <= 1'b1;
                        status_reg <= status_next;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    grant_reg  <= '0;
                    status_reg <= STATUS_OK;
                    rr_ptr_reg <= rr_next;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign grant       = grant_reg;
    assign done        = done_reg;
    assign status      = status_reg;
    assign deser_start = start_reg;
    assign deser_abort = abort_reg;
    assign out_valid   = !fifo_empty;

endmodule

// File: tb/tb_deser_frame_scheduler.sv
// Directed bench for deser_frame_scheduler: single frame, round-robin, overflow,
// push-at-full with pop, timeout, length error and mid-frame reset.
module tb_deser_frame_scheduler;
    localparam int NUM_REQ         = 4;
    localparam int WORD_SIZE       = 8;
    localparam int WORDS_PER_FRAME = 2;
    localparam int FIFO_DEPTH      = 4;
    localparam int TIMEOUT_CYCLES  = 1024;

    logic                 clock = 1'b0;
    logic                 reset_n = 1'b1;
    logic [NUM_REQ-1:0]   req = '0;
    logic [NUM_REQ-1:0]   grant;
    logic                 done;
    logic [1:0]           status;
    logic                 deser_start;
    logic                 deser_abort;
    logic                 deser_busy = 1'b0;
    logic                 deser_rco = 1'b0;
    logic [WORD_SIZE-1:0] deser_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [WORD_SIZE-1:0] out_data;

    int             checks = 0;
    int             errors = 0;
    int             done_cnt = 0;
    int             clash_cnt = 0;
    int             lat;
    int             n;
    int             dc;
    logic [7:0]     rx_q [$];
    logic [3:0]     rr_exp [5];

    deser_frame_scheduler #(
        .NUM_REQ         (NUM_REQ),
        .WORD_SIZE       (WORD_SIZE),
        .WORDS_PER_FRAME (WORDS_PER_FRAME),
        .FIFO_DEPTH      (FIFO_DEPTH),
        .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .grant       (grant),
        .done        (done),
        .status      (status),
        .deser_start (deser_start),
        .deser_abort (deser_abort),
        .deser_busy  (deser_busy),
        .deser_rco   (deser_rco),
        .deser_data  (deser_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
    );

    always #5 clock = ~clock;

    // Sample on the falling edge: words handed to the consumer, done pulses, start/abort overlap.
    always @(negedge clock) begin
        if (out_valid && out_ready) rx_q.push_back(out_data);
        if (done) done_cnt++;
        if (deser_start && deser_abort) clash_cnt++;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        req        = '0;
        deser_busy = 1'b0;
        deser_rco  = 1'b0;
        deser_data = '0;
        out_ready  = 1'b0;
        #1;
        check_value("reset_outputs",
                    {grant, done, status, deser_start, deser_abort, out_valid, out_data}, 0);
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic start_frame(input logic [NUM_REQ-1:0] req_vec, input logic [NUM_REQ-1:0] exp_grant,
                               input string tag, input int exp_lat);
        int k = 0;
        req        = req_vec;
        deser_busy = 1'b1;
        while (!deser_start && k < 10) begin
            step();
            k++;
        end
        check_value({tag, "_start"}, deser_start, 1);
        check_value({tag, "_start_latency"}, k, exp_lat);
        check_value({tag, "_grant"}, grant, exp_grant);
        step();
        check_value({tag, "_start_pulse"}, deser_start, 0);
    endtask

    task automatic send_word(input logic [7:0] d);
        deser_rco  = 1'b1;
        deser_data = d;
        step();
        deser_rco  = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input logic [1:0] exp_status,
                                input logic [NUM_REQ-1:0] exp_grant, input logic drop_req,
                                output int steps);
        int k = 0;
        deser_busy = 1'b0;
        while (!done && k < 100) begin
            step();
            k++;
        end
        check_value({tag, "_done"}, done, 1);
        check_value({tag, "_status"}, status, exp_status);
        check_value({tag, "_done_grant"}, grant, exp_grant);
        $display("frame %s: grant=%b status=%b cycles_to_done=%0d", tag, grant, status, k);
        if (drop_req) req = '0;
        steps = k;
    endtask

    task automatic idle_check(input string tag);
        step();
        check_value({tag, "_done_pulse"}, done, 0);
        check_value({tag, "_grant_clear"}, grant, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000;
        rr_exp[4] = 4'b0001;

        // Single frame, two words, consumer always ready.
        do_reset();
        rx_q.delete();
        out_ready = 1'b1;
        start_frame(4'b0001, 4'b0001, "single", 1);
        check_value("single_empty", out_valid, 0);
        send_word(8'hA5);
        check_value("single_valid", out_valid, 1);
        check_value("single_head0", out_data, 8'hA5);
        send_word(8'h3C);
        check_value("single_head1", out_data, 8'h3C);
        finish_frame("single", 2'b00, 4'b0001, 1'b1, lat);
        check_value("single_done_latency", lat, 2);
        idle_check("single");
        check_value("single_rx_count", rx_q.size(), 2);
        check_value("single_rx0", rx_q[0], 8'hA5);
        check_value("single_rx1", rx_q[1], 8'h3C);

        // Round-robin with all requests held.
        do_reset();
        rx_q.delete();
        out_ready = 1'b1;
        for (int f = 0; f < 5; f++) begin
            start_frame(4'b1111, rr_exp[f], $sformatf("rr%0d", f), (f == 0) ? 1 : 2);
            send_word(8'(8'h40 + f));
            send_word(8'(8'h50 + f));
            finish_frame($sformatf("rr%0d", f), 2'b00, rr_exp[f], f == 4, lat);
        end
        idle_check("rr");
        check_value("rr_rx_count", rx_q.size(), 10);

        // Overflow: five words into a four-deep FIFO with the consumer stalled.
        rx_q.delete();
        out_ready = 1'b0;
        start_frame(4'b0010, 4'b0010, "ovf", 1);
        for (int i = 0; i < 5; i++) send_word(8'(8'h10 + i));
        check_value("ovf_head", out_data, 8'h10);
        out_ready = 1'b1;
        finish_frame("ovf", 2'b10, 4'b0010, 1'b1, lat);
        idle_check("ovf");
        check_value("ovf_rx_count", rx_q.size(), 4);
        for (int i = 0; i < 4; i++) check_value($sformatf("ovf_rx%0d", i), rx_q[i], 8'(8'h10 + i));

        // Push at full with a simultaneous pop; five words gives a length error, not overflow.
        rx_q.delete();
        out_ready = 1'b0;
        start_frame(4'b0001, 4'b0001, "fullpop", 1);
        for (int i = 0; i < 4; i++) send_word(8'(8'h20 + i));
        check_value("fullpop_head", out_data, 8'h20);
        out_ready = 1'b1;
        send_word(8'h24);
        finish_frame("fullpop", 2'b01, 4'b0001, 1'b1, lat);
        idle_check("fullpop");
        check_value("fullpop_rx_count", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) check_value($sformatf("fullpop_rx%0d", i), rx_q[i], 8'(8'h20 + i));

        // Timeout: busy never falls; abort pulse after TIMEOUT_CYCLES cycles in COLLECT.
        rx_q.delete();
        out_ready = 1'b0;
        start_frame(4'b1001, 4'b1000, "tmo", 1);
        send_word(8'h5A);
        n = 1;
        while (!deser_abort && n < 2000) begin
            step();
            n++;
        end
        check_value("tmo_abort", deser_abort, 1);
        check_value("tmo_abort_cycles", n, TIMEOUT_CYCLES);
        step();
        check_value("tmo_abort_pulse", deser_abort, 0);
        check_value("tmo_buffered", out_valid, 1);
        out_ready = 1'b1;
        finish_frame("tmo", 2'b11, 4'b1000, 1'b1, lat);
        idle_check("tmo");
        check_value("tmo_rx_count", rx_q.size(), 1);
        check_value("tmo_rx0", rx_q[0], 8'h5A);

        // Length error: a single word, then busy falls.
        rx_q.delete();
        out_ready = 1'b1;
        start_frame(4'b0110, 4'b0010, "len", 1);
        send_word(8'h66);
        finish_frame("len", 2'b01, 4'b0010, 1'b1, lat);
        idle_check("len");
        check_value("len_rx0", rx_q[0], 8'h66);

        // Asynchronous reset in the middle of COLLECT.
        out_ready = 1'b0;
        start_frame(4'b0100, 4'b0100, "rst", 1);
        send_word(8'h77);
        check_value("rst_buffered", out_valid, 1);
        dc = done_cnt;
        #2;
        reset_n = 1'b0;
        #1;
        check_value("rst_async_outputs",
                    {grant, done, status, deser_start, deser_abort, out_valid, out_data}, 0);
        req        = '0;
        deser_busy = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        step();
        step();
        check_value("rst_no_done", done_cnt, dc);
        check_value("rst_fifo_empty", out_valid, 0);
        check_value("rst_grant", grant, 0);

        check_value("done_total", done_cnt, 10);
        check_value("start_abort_overlap", clash_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
